// File: rtl/carry_bypass_adder_pipe_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined carry-bypass adder.
// Stage k covers blocks k*BPS .. min((k+1)*BPS, NUM_BLOCKS)-1; the helpers give its bit span.
package carry_bypass_adder_pipe_pkg;

  localparam int CBA_DEFAULT_BLOCK_LEN = 4;

  function automatic int cba_min(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  function automatic int cba_ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  function automatic int cba_num_blocks(input int width, input int block_len);
    return width / block_len;
  endfunction

  function automatic int cba_num_stages(input int width, input int block_len, input int bps);
    return cba_ceil_div(cba_num_blocks(width, block_len), bps);
  endfunction

  function automatic int cba_stage_lo(input int k, input int block_len, input int bps);
    return k * bps * block_len;
  endfunction

  function automatic int cba_stage_hi(input int k, input int width, input int block_len,
                                      input int bps);
    return cba_min((k + 1) * bps, width / block_len) * block_len - 1;
  endfunction

endpackage

// File: rtl/carry_bypass_adder_pipe_if.sv
// Operand/result bundle of the pipelined carry-bypass adder.
interface carry_bypass_adder_pipe_if #(
  parameter int WIDTH = 32
);
  // Valid/hold: when hold=0 the pipe advances and in_valid/a/b/cin are captured at the
  // rising edge; when hold=1 nothing moves and the inputs are ignored, so the source must
  // keep its operands until hold drops. out_valid qualifies sum/cout/ovf; there is no
  // backpressure beyond hold.
  logic             in_valid;
  logic             hold;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, hold, a, b, cin,
    input  out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, hold, a, b, cin,
    output out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/carry_bypass_adder_pipe_block.sv
// One carry-bypass block: sums ripple from cin, the carry out skips the ripple chain
// whenever every bit of the block propagates.
module carry_bypass_block
  import carry_bypass_adder_pipe_pkg::*;
#(
  parameter int BLOCK_LEN = CBA_DEFAULT_BLOCK_LEN
) (
  input  logic [BLOCK_LEN-1:0] a,
  input  logic [BLOCK_LEN-1:0] b,
  input  logic                 cin,
  output logic [BLOCK_LEN-1:0] sum,
  output logic                 cout,
  output logic                 p
);

  logic [BLOCK_LEN:0]   c;
  logic [BLOCK_LEN-1:0] t;

  always_comb begin
    t    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < BLOCK_LEN; i++) begin
      c[i+1] = (a[i] & b[i]) | (t[i] & c[i]);
    end
    sum  = t ^ c[BLOCK_LEN-1:0];
    p    = &t;
    cout = p ? cin : c[BLOCK_LEN];
  end

endmodule

// File: rtl/carry_bypass_adder_pipe.sv
// Pipelined carry-bypass adder: blocks grouped into register stages, with skew registers
// carrying unused upper operand slices forward and de-skew registers collecting low sums.
module carry_bypass_adder_pipe
  import carry_bypass_adder_pipe_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int BLOCK_LEN        = CBA_DEFAULT_BLOCK_LEN,
  parameter int BLOCKS_PER_STAGE = 2
) (
  input logic                       clk,
  input logic                       rst,
  carry_bypass_adder_pipe_if.slave  bus
);

  localparam int NUM_BLOCKS = cba_num_blocks(WIDTH, BLOCK_LEN);
  localparam int NUM_STAGES = cba_num_stages(WIDTH, BLOCK_LEN, BLOCKS_PER_STAGE);

  if (WIDTH % BLOCK_LEN != 0) begin : g_bad_width
    $error("carry_bypass_adder_pipe: WIDTH must be a multiple of BLOCK_LEN");
  end
  if (BLOCKS_PER_STAGE < 1) begin : g_bad_bps
    $error("carry_bypass_adder_pipe: BLOCKS_PER_STAGE must be at least 1");
  end
  if (NUM_BLOCKS < 1) begin : g_bad_blocks
    $error("carry_bypass_adder_pipe: WIDTH must hold at least one block");
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int LO   = cba_stage_lo(k, BLOCK_LEN, BLOCKS_PER_STAGE);
    localparam int HI   = cba_stage_hi(k, WIDTH, BLOCK_LEN, BLOCKS_PER_STAGE);
    localparam int SBLK = (HI - LO + 1) / BLOCK_LEN;

    logic [HI:LO] a_s;
    logic [HI:LO] b_s;
    logic [HI:LO] s_s;
    logic         c_s;
    logic         v_s;
    logic         c_out_s;

    logic         valid_q, valid_d;
    logic         carry_q, carry_d;
    logic [HI:0]  sum_q, sum_d;

    if (k == 0) begin : g_src
      assign a_s = bus.a[HI:LO];
      assign b_s = bus.b[HI:LO];
      assign c_s = bus.cin;
      assign v_s = bus.in_valid;
      always_comb begin
        sum_d = s_s;
      end
    end else begin : g_src
      assign a_s = g_stage[k-1].g_skew.a_q[HI:LO];
      assign b_s = g_stage[k-1].g_skew.b_q[HI:LO];
      assign c_s = g_stage[k-1].carry_q;
      assign v_s = g_stage[k-1].valid_q;
      always_comb begin
        sum_d = {s_s, g_stage[k-1].sum_q};
      end
    end

    // Block carries chain combinationally inside the stage only.
    for (genvar j = 0; j < SBLK; j++) begin : g_blk
      localparam int BLO = LO + j * BLOCK_LEN;
      logic ci;
      logic co;
      logic p_unused;

      if (j == 0) begin : g_ci
        assign ci = c_s;
      end else begin : g_ci
        assign ci = g_blk[j-1].co;
      end

      carry_bypass_block #(
        .BLOCK_LEN (BLOCK_LEN)
      ) u_blk (
        .a    (a_s[BLO +: BLOCK_LEN]),
        .b    (b_s[BLO +: BLOCK_LEN]),
        .cin  (ci),
        .sum  (s_s[BLO +: BLOCK_LEN]),
        .cout (co),
        .p    (p_unused)
      );
    end

    assign c_out_s = g_blk[SBLK-1].co;

    always_comb begin
      valid_d = v_s;
      carry_d = c_out_s;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (!bus.hold) begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        sum_q   <= sum_d;
      end
    end

    if (k < NUM_STAGES - 1) begin : g_skew
      logic [WIDTH-1:HI+1] a_q, a_d;
      logic [WIDTH-1:HI+1] b_q, b_d;

      if (k == 0) begin : g_in
        always_comb begin
          a_d = bus.a[WIDTH-1:HI+1];
          b_d = bus.b[WIDTH-1:HI+1];
        end
      end else begin : g_in
        always_comb begin
          a_d = g_stage[k-1].g_skew.a_q[WIDTH-1:HI+1];
          b_d = g_stage[k-1].g_skew.b_q[WIDTH-1:HI+1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!bus.hold) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : g_out
      logic ovf_q, ovf_d;

      // The carry into the MSB is recovered from the MSB's own sum bit.
      always_comb begin
        ovf_d = (a_s[WIDTH-1] ^ b_s[WIDTH-1] ^ s_s[WIDTH-1]) ^ c_out_s;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (!bus.hold) begin
          ovf_q <= ovf_d;
        end
      end

      assign bus.out_valid = valid_q;
      assign bus.sum       = sum_q;
      assign bus.cout      = carry_q;
      assign bus.ovf       = ovf_q;
    end
  end

endmodule
